// File: rtl/fetch_ctrl.sv
// IF-stage sequencing controller: drives Branch/Halt to the IF unit,
// inserts memory-wait stalls and post-redirect flush bubbles, keeps perf counters.
module fetch_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             Start,
  input  logic             Mem_ready,
  input  logic             Is_branch,
  input  logic             Is_jump,
  input  logic             Is_halt,
  input  logic             Zero,
  input  logic             Resume,
  output logic [1:0]       Branch,
  output logic             Halt,
  output logic             Instr_valid,
  output logic             Flush,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Retired,
  output logic [CNT_W-1:0] Stall_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [1:0] FC = 2'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic issue;
  logic redirect;

  assign issue    = (state_q == S_FETCH) & Mem_ready;
  assign redirect = Is_jump | (Is_branch & Zero);

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!Mem_ready) begin
          state_d = S_WAIT;
        end else if (Is_halt) begin
          state_d = S_HALTED;
        end else if (redirect) begin
          if (FC != 2'd0) begin
            state_d = S_FLUSH;
            fcnt_d  = FC;
          end
        end
      end
      S_WAIT: begin
        if (Mem_ready) state_d = S_FETCH;
      end
      S_FLUSH: begin
        // the last bubble is the one that sees a count of 1
        if (fcnt_q <= 2'd1) begin
          state_d = S_FETCH;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      S_HALTED: begin
        if (Resume) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    ret_d   = ret_q;
    stall_d = stall_q;
    if (state_q == S_IDLE && Start) begin
      ret_d   = '0;
      stall_d = '0;
    end else begin
      if (issue && ret_q != CNT_MAX)
        ret_d = ret_q + CNT_ONE;
      if ((state_q == S_WAIT || state_q == S_FLUSH) && stall_q != CNT_MAX)
        stall_d = stall_q + CNT_ONE;
    end
  end

  always_comb begin
    Branch      = 2'd3;
    Halt        = 1'b1;
    Instr_valid = 1'b0;
    Flush       = 1'b0;
    if (issue) begin
      Instr_valid = 1'b1;
      Halt        = 1'b0;
      if (Is_halt) begin
        Branch = 2'd3;
        Halt   = 1'b1;
      end else if (Is_jump) begin
        Branch = 2'd2;
      end else if (Is_branch & Zero) begin
        Branch = 2'd1;
      end else begin
        Branch = 2'd0;
      end
    end
    if (state_q == S_FLUSH) Flush = 1'b1;
  end

  assign State        = state_q;
  assign Retired      = ret_q;
  assign Stall_cycles = stall_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: three instances share stimulus
// (FLUSH_CYCLES=1, FLUSH_CYCLES=3, CNT_W=4).
module tb_fetch_ctrl;

  logic CLK = 1'b0;
  logic Init = 1'b1;
  logic Start = 1'b0;
  logic Mem_ready = 1'b0;
  logic Is_branch = 1'b0;
  logic Is_jump = 1'b0;
  logic Is_halt = 1'b0;
  logic Zero = 1'b0;
  logic Resume = 1'b0;

  logic [1:0]  a_branch, b_branch, c_branch;
  logic        a_halt, b_halt, c_halt;
  logic        a_iv, b_iv, c_iv;
  logic        a_flush, b_flush, c_flush;
  logic [2:0]  a_state, b_state, c_state;
  logic [15:0] a_ret, a_stall, b_ret, b_stall;
  logic [3:0]  c_ret, c_stall;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fetch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_a (
    .CLK(CLK), .Init(Init), .Start(Start), .Mem_ready(Mem_ready),
    .Is_branch(Is_branch), .Is_jump(Is_jump), .Is_halt(Is_halt),
    .Zero(Zero), .Resume(Resume), .Branch(a_branch), .Halt(a_halt),
    .Instr_valid(a_iv), .Flush(a_flush), .State(a_state),
    .Retired(a_ret), .Stall_cycles(a_stall)
  );

  fetch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_b (
    .CLK(CLK), .Init(Init), .Start(Start), .Mem_ready(Mem_ready),
    .Is_branch(Is_branch), .Is_jump(Is_jump), .Is_halt(Is_halt),
    .Zero(Zero), .Resume(Resume), .Branch(b_branch), .Halt(b_halt),
    .Instr_valid(b_iv), .Flush(b_flush), .State(b_state),
    .Retired(b_ret), .Stall_cycles(b_stall)
  );

  fetch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_c (
    .CLK(CLK), .Init(Init), .Start(Start), .Mem_ready(Mem_ready),
    .Is_branch(Is_branch), .Is_jump(Is_jump), .Is_halt(Is_halt),
    .Zero(Zero), .Resume(Resume), .Branch(c_branch), .Halt(c_halt),
    .Instr_valid(c_iv), .Flush(c_flush), .State(c_state),
    .Retired(c_ret), .Stall_cycles(c_stall)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (a_state !== 3'd0) begin
      failures++; $display("FAIL rst_state got=%0d exp=0", a_state);
    end
    checks++;
    if (a_branch !== 2'd3 || a_halt !== 1'b1) begin
      failures++; $display("FAIL rst_drive branch=%0d halt=%0b exp=3/1", a_branch, a_halt);
    end
    checks++;
    if (a_iv !== 1'b0 || a_flush !== 1'b0) begin
      failures++; $display("FAIL rst_iv_flush iv=%0b flush=%0b exp=0/0", a_iv, a_flush);
    end
    checks++;
    if (a_ret !== 16'd0 || a_stall !== 16'd0) begin
      failures++; $display("FAIL rst_cnt ret=%0d stall=%0d exp=0/0", a_ret, a_stall);
    end
    Start = 1'b1;
    Mem_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (a_state !== 3'd0 || a_halt !== 1'b1 || a_branch !== 2'd3) begin
      failures++;
      $display("FAIL rst_hold state=%0d halt=%0b branch=%0d exp=0/1/3", a_state, a_halt, a_branch);
    end
    Start = 1'b0;
    Init = 1'b0;
  endtask

  task automatic test_start;
    while ($time < 96) tick();
    Start = 1'b1;
    Mem_ready = 1'b1;
    #1;
    checks++;
    if (a_state !== 3'd0 || a_halt !== 1'b1) begin
      failures++; $display("FAIL start_pre state=%0d halt=%0b exp=0/1", a_state, a_halt);
    end
    tick();
    Start = 1'b0;
    #1;
    checks++;
    if (a_state !== 3'd1 || a_branch !== 2'd0 || a_halt !== 1'b0 || a_iv !== 1'b1) begin
      failures++;
      $display("FAIL start_first state=%0d br=%0d halt=%0b iv=%0b exp=1/0/0/1",
               a_state, a_branch, a_halt, a_iv);
    end
    checks++;
    if (a_ret !== 16'd0) begin
      failures++; $display("FAIL start_ret0 got=%0d exp=0", a_ret);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if (a_branch !== 2'd0 || a_ret !== 16'(i + 1)) begin
        failures++;
        $display("FAIL start_seq%0d br=%0d ret=%0d exp=0/%0d", i, a_branch, a_ret, i + 1);
      end
    end
  endtask

  task automatic test_mem_stall;
    for (int i = 0; i < 4; i++) begin
      tick();
      Mem_ready = (i == 3);
      #1;
      checks++;
      if (a_halt !== 1'b1 || a_branch !== 2'd3 || a_iv !== 1'b0) begin
        failures++;
        $display("FAIL stall_drive%0d halt=%0b br=%0d iv=%0b exp=1/3/0", i, a_halt, a_branch, a_iv);
      end
      checks++;
      if (a_state !== ((i == 0) ? 3'd1 : 3'd2)) begin
        failures++; $display("FAIL stall_state%0d got=%0d", i, a_state);
      end
      checks++;
      if (a_stall !== ((i < 2) ? 16'd0 : 16'(i - 1))) begin
        failures++; $display("FAIL stall_cnt%0d got=%0d", i, a_stall);
      end
    end
    tick();
    #1;
    checks++;
    if (a_state !== 3'd1 || a_iv !== 1'b1 || a_halt !== 1'b0) begin
      failures++;
      $display("FAIL stall_reissue state=%0d iv=%0b halt=%0b exp=1/1/0", a_state, a_iv, a_halt);
    end
    checks++;
    if (a_stall !== 16'd3 || a_ret !== 16'd5) begin
      failures++; $display("FAIL stall_counts stall=%0d ret=%0d exp=3/5", a_stall, a_ret);
    end
  endtask

  task automatic test_branch;
    tick();
    Is_branch = 1'b1;
    Zero = 1'b1;
    #1;
    checks++;
    if (a_branch !== 2'd1 || a_iv !== 1'b1 || a_flush !== 1'b0) begin
      failures++;
      $display("FAIL br_taken br=%0d iv=%0b flush=%0b exp=1/1/0", a_branch, a_iv, a_flush);
    end
    tick();
    Is_branch = 1'b0;
    Zero = 1'b0;
    #1;
    checks++;
    if (a_state !== 3'd3 || a_flush !== 1'b1 || a_branch !== 2'd3 || a_halt !== 1'b1) begin
      failures++;
      $display("FAIL br_flush state=%0d flush=%0b br=%0d halt=%0b exp=3/1/3/1",
               a_state, a_flush, a_branch, a_halt);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 3'd1 || a_flush !== 1'b0 || a_stall !== 16'd4) begin
      failures++;
      $display("FAIL br_after state=%0d flush=%0b stall=%0d exp=1/0/4", a_state, a_flush, a_stall);
    end
    tick();
    Is_branch = 1'b1;
    Zero = 1'b0;
    #1;
    checks++;
    if (a_branch !== 2'd0 || a_iv !== 1'b1) begin
      failures++; $display("FAIL br_not_taken br=%0d iv=%0b exp=0/1", a_branch, a_iv);
    end
    tick();
    Is_branch = 1'b0;
    #1;
    checks++;
    if (a_state !== 3'd1 || a_flush !== 1'b0 || a_stall !== 16'd4) begin
      failures++;
      $display("FAIL br_nt_noflush state=%0d flush=%0b stall=%0d exp=1/0/4", a_state, a_flush, a_stall);
    end
    tick();
    Is_jump = 1'b1;
    Is_branch = 1'b1;
    Zero = 1'b1;
    #1;
    checks++;
    if (a_branch !== 2'd2) begin
      failures++; $display("FAIL br_jump_prio got=%0d exp=2", a_branch);
    end
    tick();
    Is_jump = 1'b0;
    Is_branch = 1'b0;
    Zero = 1'b0;
    #1;
    checks++;
    if (a_state !== 3'd3 || a_flush !== 1'b1) begin
      failures++; $display("FAIL br_jump_flush state=%0d flush=%0b exp=3/1", a_state, a_flush);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 3'd1 || a_stall !== 16'd5) begin
      failures++; $display("FAIL br_jump_after state=%0d stall=%0d exp=1/5", a_state, a_stall);
    end
  endtask

  task automatic test_back_to_back;
    tick();
    Is_branch = 1'b1;
    Zero = 1'b1;
    #1;
    checks++;
    if (a_branch !== 2'd1) begin
      failures++; $display("FAIL b2b_first got=%0d exp=1", a_branch);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 3'd3 || a_branch !== 2'd3 || a_iv !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ignored state=%0d br=%0d iv=%0b exp=3/3/0", a_state, a_branch, a_iv);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 3'd1 || a_branch !== 2'd1) begin
      failures++; $display("FAIL b2b_second state=%0d br=%0d exp=1/1", a_state, a_branch);
    end
    tick();
    Is_branch = 1'b0;
    Zero = 1'b0;
    #1;
    checks++;
    if (a_state !== 3'd3) begin
      failures++; $display("FAIL b2b_flush2 got=%0d exp=3", a_state);
    end
    tick();
    #1;
    checks++;
    if (a_state !== 3'd1 || a_branch !== 2'd0 || a_stall !== 16'd7) begin
      failures++;
      $display("FAIL b2b_end state=%0d br=%0d stall=%0d exp=1/0/7", a_state, a_branch, a_stall);
    end
  endtask

  task automatic test_halt_resume;
    tick();
    Is_halt = 1'b1;
    Is_jump = 1'b1;
    #1;
    checks++;
    if (a_branch !== 2'd3 || a_halt !== 1'b1 || a_iv !== 1'b1) begin
      failures++;
      $display("FAIL halt_instr br=%0d halt=%0b iv=%0b exp=3/1/1", a_branch, a_halt, a_iv);
    end
    tick();
    Is_halt = 1'b0;
    Is_jump = 1'b0;
    Start = 1'b1;
    #1;
    checks++;
    if (a_state !== 3'd4 || a_halt !== 1'b1 || a_branch !== 2'd3 || a_ret !== 16'd16) begin
      failures++;
      $display("FAIL halt_state state=%0d halt=%0b br=%0d ret=%0d exp=4/1/3/16",
               a_state, a_halt, a_branch, a_ret);
    end
    tick();
    Start = 1'b0;
    Resume = 1'b1;
    #1;
    checks++;
    if (a_state !== 3'd4) begin
      failures++; $display("FAIL halt_start_ignored got=%0d exp=4", a_state);
    end
    tick();
    Resume = 1'b0;
    #1;
    checks++;
    if (a_state !== 3'd1 || a_iv !== 1'b1 || a_halt !== 1'b0 || a_ret !== 16'd16) begin
      failures++;
      $display("FAIL halt_resume state=%0d iv=%0b halt=%0b ret=%0d exp=1/1/0/16",
               a_state, a_iv, a_halt, a_ret);
    end
    Is_halt = 1'b1;
    tick();
    Is_halt = 1'b0;
    Start = 1'b1;
    Resume = 1'b1;
    #1;
    checks++;
    if (a_state !== 3'd4 || a_ret !== 16'd17) begin
      failures++; $display("FAIL halt2 state=%0d ret=%0d exp=4/17", a_state, a_ret);
    end
    tick();
    Start = 1'b0;
    Resume = 1'b0;
    #1;
    checks++;
    if (a_state !== 3'd1 || a_ret !== 16'd17 || a_stall !== 16'd7) begin
      failures++;
      $display("FAIL halt_both state=%0d ret=%0d stall=%0d exp=1/17/7", a_state, a_ret, a_stall);
    end
  endtask

  task automatic test_reset_mid_flush;
    tick();
    Init = 1'b1;
    tick();
    Init = 1'b0;
    Start = 1'b1;
    Mem_ready = 1'b1;
    tick();
    Start = 1'b0;
    Is_branch = 1'b1;
    Zero = 1'b1;
    #1;
    checks++;
    if (b_state !== 3'd1 || b_branch !== 2'd1) begin
      failures++; $display("FAIL rmf_branch state=%0d br=%0d exp=1/1", b_state, b_branch);
    end
    tick();
    Is_branch = 1'b0;
    Zero = 1'b0;
    #1;
    checks++;
    if (b_state !== 3'd3 || b_flush !== 1'b1) begin
      failures++; $display("FAIL rmf_flush1 state=%0d flush=%0b exp=3/1", b_state, b_flush);
    end
    tick();
    checks++;
    if (b_state !== 3'd3 || b_stall !== 16'd1 || b_ret !== 16'd1) begin
      failures++;
      $display("FAIL rmf_flush2 state=%0d stall=%0d ret=%0d exp=3/1/1", b_state, b_stall, b_ret);
    end
    Init = 1'b1;
    #1;
    checks++;
    if (b_state !== 3'd0 || b_flush !== 1'b0 || b_ret !== 16'd0 || b_stall !== 16'd0) begin
      failures++;
      $display("FAIL rmf_async state=%0d flush=%0b ret=%0d stall=%0d exp=0/0/0/0",
               b_state, b_flush, b_ret, b_stall);
    end
    checks++;
    if (b_branch !== 2'd3 || b_halt !== 1'b1) begin
      failures++; $display("FAIL rmf_drive br=%0d halt=%0b exp=3/1", b_branch, b_halt);
    end
    tick();
    Init = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    #1;
    checks++;
    if (b_state !== 3'd1 || b_flush !== 1'b0 || b_iv !== 1'b1) begin
      failures++;
      $display("FAIL rmf_restart state=%0d flush=%0b iv=%0b exp=1/0/1", b_state, b_flush, b_iv);
    end
    tick();
    checks++;
    if (b_state !== 3'd1 || b_flush !== 1'b0) begin
      failures++; $display("FAIL rmf_no_resume state=%0d flush=%0b exp=1/0", b_state, b_flush);
    end
    Is_branch = 1'b1;
    Zero = 1'b1;
    tick();
    Is_branch = 1'b0;
    Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Mem_ready = (i != 0);
      #1;
      checks++;
      if (b_state !== 3'd3 || b_flush !== 1'b1) begin
        failures++; $display("FAIL rmf_len%0d state=%0d flush=%0b exp=3/1", i, b_state, b_flush);
      end
      tick();
    end
    Mem_ready = 1'b1;
    #1;
    checks++;
    if (b_state !== 3'd1 || b_iv !== 1'b1 || b_stall !== 16'd3) begin
      failures++;
      $display("FAIL rmf_len_end state=%0d iv=%0b stall=%0d exp=1/1/3", b_state, b_iv, b_stall);
    end
  endtask

  task automatic test_saturation;
    tick();
    Init = 1'b1;
    tick();
    Init = 1'b0;
    Start = 1'b1;
    Mem_ready = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (c_ret !== ((i > 15) ? 4'd15 : 4'(i))) begin
        failures++; $display("FAIL sat_ret%0d got=%0d", i, c_ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_mem_stall();
    test_branch();
    test_back_to_back();
    test_halt_resume();
    test_reset_mid_flush();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
